// File: rtl/tt_frame_sender.sv
// tt_frame_sender: sends a 4-byte 8N1 frame (sync, seq, payload, xor checksum) on each trig rising edge
//   clk, rst         clock and synchronous active-high reset
//   trig, payload    slot trigger (edge detected) and data byte latched on the accepted edge
//   txd              serial line, idle high
//   busy, done       frame in flight / one-cycle pulse after the last stop bit
//   seq, overrun_cnt sequence number of the next frame / saturating count of triggers rejected while busy
module tt_frame_sender #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [7:0]  payload,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  seq,
    output logic [15:0] overrun_cnt
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic          trig_q;
    logic          ev;
    logic          cell_end;
    logic [1:0]    k;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [7:0]    payload_reg;
    logic [7:0]    chk_reg;
    logic [7:0]    cur_byte;
    always_comb begin
        ev       = trig & ~trig_q;
        cell_end = cnt == CNT_MAX;
        cur_byte = k == 2'd0 ? SYNC_BYTE : k == 2'd1 ? seq : k == 2'd2 ? payload_reg : chk_reg;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            trig_q      <= 1'b0;
            k           <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            payload_reg <= '0;
            chk_reg     <= '0;
            txd         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            seq         <= '0;
            overrun_cnt <= '0;
        end else begin
            trig_q <= trig;
            done   <= 1'b0;
            cnt    <= (state == IDLE || cell_end) ? '0 : cnt + 1'b1;
            if (ev && state != IDLE && overrun_cnt != 16'hFFFF)
                overrun_cnt <= overrun_cnt + 16'd1;
            case (state)
                IDLE: if (ev) begin
                    payload_reg <= payload;
                    chk_reg     <= SYNC_BYTE ^ seq ^ payload;
                    k           <= '0;
                    state       <= START;
                    busy        <= 1'b1;
                    txd         <= 1'b0;
                end
                START: if (cell_end) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    txd     <= cur_byte[0];
                end
                DATA: if (cell_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        txd     <= cur_byte[bit_idx + 3'd1];
                    end
                end
                STOP: if (cell_end) begin
                    if (k == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        seq   <= seq + 8'd1;
                    end else begin
                        k     <= k + 2'd1;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_frame_sender.sv
// tb_tt_frame_sender: directed checks of reset, framing, held/mid-frame/back-to-back triggers and mid-frame reset
module tb_tt_frame_sender;
    localparam int CPB = 4;
    localparam int BL  = 10 * CPB;
    localparam int FL  = 40 * CPB;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [7:0]  payload = 8'h00;
    logic        txd;
    logic        busy;
    logic        done;
    logic [7:0]  seq;
    logic [15:0] overrun_cnt;
    int n_vec = 0;
    int n_err = 0;
    logic rec_txd  [0:511];
    logic rec_done [0:511];
    logic rec_busy [0:511];
    tt_frame_sender #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .trig(trig), .payload(payload),
        .txd(txd), .busy(busy), .done(done), .seq(seq), .overrun_cnt(overrun_cnt)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic capture(input int n, input int on, input int off, input logic [7:0] pl,
                           input int on2, input logic [7:0] pl2);
        for (int i = 0; i < n; i++) begin
            rec_txd[i]  = txd;
            rec_done[i] = done;
            rec_busy[i] = busy;
            if (i == on) payload = pl;
            if (i == on2) payload = pl2;
            trig = (i >= on && i < off) || i == on2;
            tick();
        end
    endtask
    function automatic logic [7:0] get_byte(input int j);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = rec_txd[j*BL + (b+1)*CPB + CPB/2];
        return v;
    endfunction
    task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp [4];
        logic fr;
        int dn;
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        fr = 1'b1;
        dn = 0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s byte%0d", tag, j), 32'(get_byte(j)), 32'(exp[j]));
            fr = fr & (rec_txd[j*BL + CPB/2] === 1'b0) & (rec_txd[j*BL + 9*CPB + CPB/2] === 1'b1);
        end
        for (int i = 0; i < FL; i++) dn += int'(rec_done[i]);
        chk($sformatf("%s start/stop bits", tag), 32'(fr), 32'd1);
        chk($sformatf("%s early done", tag), 32'(dn), 32'd0);
        chk($sformatf("%s done at 40 cells", tag), 32'(rec_done[FL]), 32'd1);
        chk($sformatf("%s busy fall", tag), 32'({rec_busy[FL-1], rec_busy[FL]}), 32'b10);
    endtask
    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) begin
            trig = i[0];
            payload = 8'h55 << i;
            tick();
            chk($sformatf("reset hold %0d", i), 32'({txd, busy, done, seq, overrun_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}));
        end
        rst = 1'b0;
        trig = 1'b0;
        tick();
        chk("reset release", 32'({txd, busy, done, seq, overrun_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}));
        trig = 1'b1;
        payload = 8'h3C;
        tick();
        chk("held first cycle busy/txd", 32'({busy, txd}), 32'b10);
        capture(330, 0, 299, 8'h3C, -1, 8'h00);
        check_frame("held", 8'hA5, 8'h00, 8'h3C, 8'h99);
        cnt = 0;
        for (int i = FL + 1; i < 330; i++) cnt += int'(rec_done[i]) + int'(rec_busy[i]);
        chk("held no second frame", 32'(cnt), 32'd0);
        chk("held overrun", 32'(overrun_cnt), 32'd0);
        chk("held seq", 32'(seq), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("idle reset seq", 32'(seq), 32'd0);
        trig = 1'b1;
        payload = 8'h3C;
        tick();
        chk("single first cycle busy/txd", 32'({busy, txd}), 32'b10);
        capture(FL + 1, 50, 51, 8'hFF, FL, 8'h10);
        check_frame("single", 8'hA5, 8'h00, 8'h3C, 8'h99);
        chk("retrigger overrun", 32'(overrun_cnt), 32'd1);
        chk("back-to-back start", 32'({busy, txd, seq}), 32'({1'b1, 1'b0, 8'h01}));
        capture(FL + 1, -1, -1, 8'h00, -1, 8'h00);
        check_frame("b2b", 8'hA5, 8'h01, 8'h10, 8'hB4);
        chk("b2b seq", 32'(seq), 32'd2);
        trig = 1'b1;
        payload = 8'h5A;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 90; i++) tick();
        chk("mid-frame busy before reset", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid-frame reset", 32'({txd, busy, done, seq, overrun_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cnt += int'(done) + int'(busy);
        end
        chk("no done after reset", 32'(cnt), 32'd0);
        trig = 1'b1;
        payload = 8'h3C;
        tick();
        capture(FL + 1, -1, -1, 8'h00, -1, 8'h00);
        check_frame("post-reset", 8'hA5, 8'h00, 8'h3C, 8'h99);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tt_frame_sender.md
Name: tt_frame_sender

Overview:
- Downstream consumer of the schedule block's `tx` slot pulse/level.
- On each rising edge of the trigger it latches a payload byte and serialises a 4-byte time-triggered frame on a UART-style 8N1 line.
- Frame content: sync byte, sequence number, payload, XOR checksum.
- Reports busy/done status and counts triggers that arrive while a frame is in flight.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit cell (>=2).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- trig  input  1  slot trigger from schedule `tx`; may stay high for many cycles.
- payload  input  8  data byte, sampled on the accepted trigger edge.
- txd  output  1  serial line, idle high.
- busy  output  1  high while a frame is being sent.
- done  output  1  single-cycle pulse after the last stop bit.
- seq  output  8  sequence number for the next frame.
- overrun_cnt  output  16  triggers rejected while busy, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: txd=1, busy=0, done=0, seq=0, overrun_cnt=0.
  - Internal: state=IDLE, trig_q=0.
  - Reset mid-frame aborts the frame; line is high after the next edge.
- Edge detect:
  - trig_q <= trig every cycle.
  - event = trig & ~trig_q.
  - A trig already high in the first cycle after reset counts as an event.
  - Held-high trig produces exactly one event.
- FSM states: IDLE, START, DATA, STOP.
  - 2-bit byte index k selects the byte: 0=SYNC_BYTE, 1=seq, 2=payload_reg, 3=chk_reg.
  - 3-bit bit index selects the bit within the byte.
  - Bit-cell counter runs 0..CLKS_PER_BIT-1.
- IDLE:
  - On event: latch payload_reg=payload and chk_reg=SYNC_BYTE^seq^payload.
  - Then k=0, go to START, busy<=1, txd<=0.
  - Latency: txd low and busy high in the cycle after the event cycle.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles.
  - If k<3: k++, go directly to START; no idle gap between bytes.
  - If k=3: go to IDLE, busy<=0, done<=1 (one cycle), seq<=seq+1 (mod 256, 255->0).
- Frame length: exactly 40*CLKS_PER_BIT cycles from the first start-bit cycle to the done cycle.
- Frame contents are stable against input changes:
  - seq output changes only at frame end.
  - Frame bytes use seq/payload values captured at acceptance.
- Overrun:
  - An event while state!=IDLE (including the final stop-bit cycle) is ignored for framing.
  - It increments overrun_cnt, saturating at 16'hFFFF.
- Simultaneous events:
  - An event in the cycle done is high is accepted (state is IDLE).
  - The new start bit begins in the next cycle, so back-to-back frames are possible.
- Outputs are registered; no combinational path from trig or payload to any output.

Test Plan:
- Reset: hold rst 3 cycles, with trig/payload toggling.
  - Required: txd=1, busy=0, done=0, seq=0, overrun_cnt=0 throughout and after release (trig held low).
- Single frame, CLKS_PER_BIT=4, payload=8'h3C, trig pulse 1 cycle.
  - Required: busy rises 1 cycle later; line decodes bytes A5, 00, 3C, 99.
  - Required: done pulses exactly 160 cycles after the first start-bit cycle; seq becomes 1.
- Held trigger: trig high for 300 cycles.
  - Required: exactly one frame, overrun_cnt=0, no second frame after done.
- Mid-frame retrigger: second rising edge at cycle 50 of a frame, with payload changed to 8'hFF.
  - Required: overrun_cnt=1; current frame bytes unchanged (A5, 00, 3C, 99).
- Back-to-back: rising edge in the done cycle with payload=8'h10 (seq=1).
  - Required: new start bit in the next cycle; bytes A5, 01, 10, B4; seq becomes 2.
- Reset mid-frame: assert rst during DATA of byte 2.
  - Required: next cycle txd=1, busy=0, seq=0, overrun_cnt=0, no done pulse.
  - Required: a subsequent trigger produces a clean frame starting with seq 00.
